mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 107 ++++++++++
 tb/tb_mul_div_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multicycle unsigned shift-add multiplier and restoring divider, one bit per cycle.
// Define MUL_DIV_DIVIDE_EN to compile in the divider datapath and DIV state.
module mul_div_unit #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [WORD_SIZE-1:0] in_a,
    input  logic [WORD_SIZE-1:0] in_b,
    input  logic [1:0]           rd_in,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result_lo,
    output logic [WORD_SIZE-1:0] result_hi,
    output logic [1:0]           rd_out,
    output logic                 div_by_zero
);
    localparam int W = WORD_SIZE;
    localparam int CW = $clog2(W) + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;
    logic [W-1:0] a_reg;
    logic [2*W-1:0] prod, prod_nxt;
    logic [CW-1:0] cnt;
    logic [1:0] rd_reg;
    logic [W:0] mul_sum;
    logic last;
`ifdef MUL_DIV_DIVIDE_EN
    logic [W-1:0] b_reg;
    logic [W:0] r_sh, diff;
    logic dz;
`endif
    assign last = cnt == CW'(W - 1);
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef MUL_DIV_DIVIDE_EN
            IDLE: if (start) state_nxt = op ? DIV : MUL;
            DIV: if (dz || last) state_nxt = DONE;
`else
            IDLE: if (start) state_nxt = op ? DONE : MUL;
`endif
            MUL: if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // prod holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum = {1'b0, prod[2*W-1:W]} + {1'b0, a_reg & {W{prod[0]}}};
`ifdef MUL_DIV_DIVIDE_EN
        dz = b_reg == '0;
        r_sh = {prod[2*W-1:W], prod[W-1]};
        diff = r_sh - {1'b0, b_reg};
        prod_nxt = state == DIV ? (diff[W] ? {r_sh[W-1:0], prod[W-2:0], 1'b0} : {diff[W-1:0], prod[W-2:0], 1'b1})
                                : {mul_sum, prod[W-1:1]};
`else
        prod_nxt = {mul_sum, prod[W-1:1]};
`endif
    end
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
`ifdef MUL_DIV_DIVIDE_EN
            b_reg <= '0;
`endif
            prod <= '0;
            cnt <= '0;
            rd_reg <= '0;
            result_lo <= '0;
            result_hi <= '0;
            rd_out <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                a_reg <= in_a;
`ifdef MUL_DIV_DIVIDE_EN
                b_reg <= in_b;
`endif
                rd_reg <= rd_in;
                cnt <= '0;
                prod <= {{W{1'b0}}, op ? in_a : in_b};
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + CW'(1);
                prod <= prod_nxt;
            end
            // results are loaded on the edge entering DONE so they are valid alongside done
            if (state_nxt == DONE) begin
                rd_out <= state == IDLE ? rd_in : rd_reg;
`ifdef MUL_DIV_DIVIDE_EN
                {result_hi, result_lo} <= (state == DIV && dz) ? {a_reg, {W{1'b1}}} : prod_nxt;
                div_by_zero <= state == DIV && dz;
`else
                {result_hi, result_lo} <= state == MUL ? prod_nxt : '0;
                div_by_zero <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic op;
    logic [15:0] in_a, in_b;
    logic [1:0] rd_in;
    logic busy, done;
    logic [15:0] result_lo, result_hi;
    logic [1:0] rd_out;
    logic div_by_zero;
    int n_chk = 0;
    int n_pass = 0;

    mul_div_unit #(.WORD_SIZE(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
        .rd_in(rd_in), .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .rd_out(rd_out), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // ign > 0 drives a spurious start with different operands in that cycle of the operation
    task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b, input logic [1:0] rd, input int ign);
        logic [31:0] e;
        logic dz;
        int exp_cyc;
        int cyc;
`ifdef MUL_DIV_DIVIDE_EN
        dz = o && b == 16'h0;
        e = !o ? 32'(a) * 32'(b) : dz ? {a, 16'hffff} : {16'(a % b), 16'(a / b)};
        exp_cyc = (o && dz) ? 2 : 17;
`else
        dz = 1'b0;
        e = o ? 32'h0 : 32'(a) * 32'(b);
        exp_cyc = o ? 1 : 17;
`endif
        op = o;
        in_a = a;
        in_b = b;
        rd_in = rd;
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc == ign) begin
                start = 1'b1;
                op = ~o;
                in_a = ~a;
                in_b = b + 16'd1;
                rd_in = ~rd;
            end else start = 1'b0;
            tick;
            cyc++;
        end
        start = 1'b0;
        check("latency", cyc, exp_cyc);
        check("result_lo", result_lo, e[15:0]);
        check("result_hi", result_hi, e[31:16]);
        check("rd_out", rd_out, rd);
        check("div_by_zero", div_by_zero, dz);
        check("busy_in_done", busy, 1);
        tick;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("hold_lo", result_lo, e[15:0]);
        check("hold_hi", result_hi, e[31:16]);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        start = 1'b0;
        op = 1'b0;
        in_a = '0;
        in_b = '0;
        rd_in = '0;
        tick;
        tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lo", result_lo, 0);
        check("rst_hi", result_hi, 0);
        check("rst_rd", rd_out, 0);
        check("rst_dbz", div_by_zero, 0);
        reset = 1'b0;
        tick;
        run_op(1'b0, 16'd3, 16'd5, 2'd2, 0);
        run_op(1'b0, 16'hffff, 16'hffff, 2'd1, 0);
        run_op(1'b1, 16'd100, 16'd7, 2'd3, 0);
        run_op(1'b1, 16'h1234, 16'h0, 2'd0, 0);
        run_op(1'b0, 16'd1234, 16'd321, 2'd1, 5);
        run_op(1'b1, 16'hbeef, 16'h0013, 2'd2, 5);
        for (int i = 0; i < 24; i++)
            run_op(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0) ? 16'hffff : 16'($urandom),
                   ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom), 2'($urandom),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 15)) : 0);
        op = 1'b0;
        in_a = 16'd77;
        in_b = 16'd99;
        rd_in = 2'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i < 8; i++) tick;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_lo", result_lo, 0);
        check("mid_rst_hi", result_hi, 0);
        check("mid_rst_rd", rd_out, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        tick;
        tick;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done || busy) seen++;
        end
        check("no_done_after_rst", seen, 0);
        run_op(1'b0, 16'd77, 16'd99, 2'd3, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
